// File: rtl/phy_tx_lane_sched.sv
// Four-lane round-robin scheduler feeding the phy_tx serializer, with a sync preamble after reset.
// Optional feature macro: PHY_TX_SCHED_IDLE_EN (fill empty slots with IDLE_SYM in RUN).
module phy_tx_lane_sched #(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter int                SYNC_CNT   = 4,
  parameter logic [DATA_W-1:0] IDLE_SYM   = 8'hBC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic              valid0,
  input  logic              valid1,
  input  logic              valid2,
  input  logic              valid3,
  output logic              ready0,
  output logic              ready1,
  output logic              ready2,
  output logic              ready3,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        lane_out,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(SYNC_CNT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  SYNC_INIT = SC_W'(SYNC_CNT);

  typedef enum logic {ST_SYNC, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [SC_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic [1:0]        lane_out_q, lane_out_d;
  logic [3:0]        ready_q, ready_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mem_q [4][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [4][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [4];
  logic [PTR_W-1:0]  wr_ptr_d [4];
  logic [PTR_W-1:0]  rd_ptr_q [4];
  logic [PTR_W-1:0]  rd_ptr_d [4];
  logic [CNT_W-1:0]  count_q [4];
  logic [CNT_W-1:0]  count_d [4];

  logic [DATA_W-1:0] lane_in [4];
  logic [3:0]        lane_valid;
  logic [3:0]        push;
  logic [3:0]        pop;
  logic [3:0]        nonempty;
  logic [3:0]        nonempty_d;

  logic              xfer;
  logic              slot_free;
  logic              sync_done;
  logic              grant_found;
  logic [1:0]        grant_lane;
  logic [1:0]        arb_idx;

  assign lane_in[0] = in0;
  assign lane_in[1] = in1;
  assign lane_in[2] = in2;
  assign lane_in[3] = in3;
  assign lane_valid = {valid3, valid2, valid1, valid0};

  assign xfer      = valid_out_q && out_ready;
  assign slot_free = !valid_out_q || xfer;
  assign sync_done = (state_q == ST_SYNC) && xfer && (sync_cnt_q == SC_W'(1));

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      push[i]     = lane_valid[i] && ready_q[i];
      nonempty[i] = (count_q[i] != '0);
    end
  end

  // Lowest offset from rr_ptr wins; scanning downwards lets the nearest lane overwrite.
  always_comb begin
    grant_found = 1'b0;
    grant_lane  = rr_ptr_q;
    arb_idx     = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      arb_idx = rr_ptr_q + 2'(k);
      if (nonempty[arb_idx]) begin
        grant_found = 1'b1;
        grant_lane  = arb_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_SYNC;
      sync_cnt_q <= SYNC_INIT;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    if (state_q == ST_SYNC && xfer) begin
      sync_cnt_d = sync_cnt_q - SC_W'(1);
      if (sync_done) begin
        state_d = ST_RUN;
      end
    end
  end

  // The final sync transfer frees the slot, so lane arbitration starts on that same edge.
  always_comb begin
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    lane_out_d  = lane_out_q;
    rr_ptr_d    = rr_ptr_q;
    pop         = '0;
    if (slot_free) begin
      if (state_q == ST_SYNC && !sync_done) begin
        data_out_d  = IDLE_SYM;
        lane_out_d  = 2'd0;
        valid_out_d = 1'b1;
      end else if (grant_found) begin
        pop[grant_lane] = 1'b1;
        data_out_d      = mem_q[grant_lane][rd_ptr_q[grant_lane]];
        lane_out_d      = grant_lane;
        valid_out_d     = 1'b1;
        rr_ptr_d        = grant_lane + 2'd1;
      end else begin
`ifdef PHY_TX_SCHED_IDLE_EN
        data_out_d  = IDLE_SYM;
        lane_out_d  = 2'd0;
        valid_out_d = 1'b1;
`else
        valid_out_d = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < 4; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = lane_in[i];
        wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      end
      if (push[i] && !pop[i]) begin
        count_d[i] = count_q[i] + CNT_W'(1);
      end else if (!push[i] && pop[i]) begin
        count_d[i] = count_q[i] - CNT_W'(1);
      end
      ready_d[i]    = (count_d[i] != FULL_CNT);
      nonempty_d[i] = (count_d[i] != '0);
    end
  end

  assign busy_d = (|nonempty_d) || valid_out_d;

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= 2'd0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      lane_out_q  <= 2'd0;
      ready_q     <= 4'b0000;
      busy_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      lane_out_q  <= lane_out_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign lane_out  = lane_out_q;
  assign busy      = busy_q;
  assign ready0    = ready_q[0];
  assign ready1    = ready_q[1];
  assign ready2    = ready_q[2];
  assign ready3    = ready_q[3];

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Bench for phy_tx_lane_sched: queue-based reference model feeds a scoreboard of expected
// transfers, and a negedge monitor compares every DUT output against the model.
module tb_phy_tx_lane_sched;

  localparam int        FIFO_DEPTH = 4;
  localparam int        SYNC_CNT   = 4;
  localparam logic [7:0] IDLE_SYM  = 8'hBC;

  logic       clk;
  logic       reset;
  logic [7:0] din [4];
  logic [3:0] vin;
  logic       out_ready;
  logic       ready0, ready1, ready2, ready3;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic       busy;

  int compared;
  int mismatched;
  bit check_en;

  // Reference model state: FIFO contents as queues, output register and sync bookkeeping.
  logic [7:0] lane_q [4][$];
  logic [9:0] exp_q [$];
  int         rr;
  bit         in_sync;
  int         sync_left;
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_lane;
  logic [3:0] m_ready;
  logic       m_busy;

  phy_tx_lane_sched #(
    .DATA_W(8), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_CNT(SYNC_CNT), .IDLE_SYM(IDLE_SYM)
  ) dut (
    .clk(clk), .reset(reset),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .valid0(vin[0]), .valid1(vin[1]), .valid2(vin[2]), .valid3(vin[3]),
    .ready0(ready0), .ready1(ready1), .ready2(ready2), .ready3(ready3),
    .out_ready(out_ready),
    .data_out(data_out), .valid_out(valid_out), .lane_out(lane_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelLoad(input logic [7:0] d, input logic [1:0] l);
    m_valid = 1'b1;
    m_data  = d;
    m_lane  = l;
    exp_q.push_back({l, d});
  endtask

  task automatic modelStep();
    logic       xfer;
    logic       free;
    logic [3:0] acc;
    int         g;
    int         idx;
    if (reset) begin
      for (int i = 0; i < 4; i++) lane_q[i].delete();
      exp_q.delete();
      rr = 0; in_sync = 1; sync_left = SYNC_CNT;
      m_valid = 0; m_data = 8'h00; m_lane = 2'd0; m_ready = 4'b0000; m_busy = 0;
    end else begin
      xfer = m_valid && out_ready;
      free = !m_valid || xfer;
      acc  = vin & m_ready;
      if (free) begin
        if (in_sync && !(xfer && sync_left == 1)) begin
          if (xfer) sync_left--;
          modelLoad(IDLE_SYM, 2'd0);
        end else begin
          in_sync = 0;
          g = -1;
          for (int k = 0; k < 4; k++) begin
            idx = (rr + k) % 4;
            if (g < 0 && lane_q[idx].size() > 0) g = idx;
          end
          if (g >= 0) begin
            modelLoad(lane_q[g].pop_front(), 2'(g));
            rr = (g + 1) % 4;
          end else begin
`ifdef PHY_TX_SCHED_IDLE_EN
            modelLoad(IDLE_SYM, 2'd0);
`else
            m_valid = 1'b0;
`endif
          end
        end
      end
      m_busy = m_valid;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) lane_q[i].push_back(din[i]);
        m_ready[i] = (lane_q[i].size() < FIFO_DEPTH);
        if (lane_q[i].size() > 0) m_busy = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
      if (reset) check_en = 1;
    end
  end

  // Monitor: per-cycle state checks plus scoreboard pop on every DUT transfer.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
        checkOutput("data_out", {24'd0, data_out}, {24'd0, m_data});
        checkOutput("lane_out", {30'd0, lane_out}, {30'd0, m_lane});
        checkOutput("ready", {28'd0, ready3, ready2, ready1, ready0}, {28'd0, m_ready});
        checkOutput("busy", {31'd0, busy}, {31'd0, m_busy});
        if (valid_out === 1'b1 && out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checkOutput("xfer_unexpected", {22'd0, lane_out, data_out}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            checkOutput("xfer_data", {24'd0, data_out}, {24'd0, e[7:0]});
            checkOutput("xfer_lane", {30'd0, lane_out}, {30'd0, e[9:8]});
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic [3:0] v,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3,
                               input logic ordy);
    @(posedge clk);
    #1;
    reset = rst; vin = v; out_ready = ordy;
    din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
  endtask

  task automatic idleCycles(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, ordy);
  endtask

  initial begin
    int  pend;
    bit  drained;
    logic [3:0] rv;
    compared = 0; mismatched = 0; check_en = 0;
    reset = 1'b1; vin = 4'b0000; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;

    // Reset, then the sync preamble with no lane traffic.
    applyStimulus(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    idleCycles(8, 1'b1);

    // All four lanes pushed on two consecutive cycles.
    applyStimulus(1'b0, 4'b1111, 8'hFF, 8'hEE, 8'hDD, 8'hCC, 1'b1);
    applyStimulus(1'b0, 4'b1111, 8'hBB, 8'hAA, 8'h99, 8'h88, 1'b1);
    idleCycles(8, 1'b1);

    // Single active lane streams back-to-back.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'b0100, 8'h00, 8'h00, 8'h77, 8'h00, 1'b1);
    idleCycles(4, 1'b1);

    // Stall output and overfill lane 0, then release.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'b0001, 8'(8'h10 + i), 8'h00, 8'h00, 8'h00, 1'b0);
    idleCycles(10, 1'b1);

    // Reset while three lanes hold data, then preamble restarts.
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'b0111, 8'h31, 8'h32, 8'h33, 8'h00, 1'b0);
    applyStimulus(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    idleCycles(10, 1'b1);

    // Randomized traffic with varying lane activity and output backpressure.
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) rv = 4'($urandom);
      applyStimulus((c == 700), rv & 4'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    // Drain with a bounded budget.
    drained = 0;
    for (int c = 0; c < 200 && !drained; c++) begin
      applyStimulus(1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      pend = 0;
      for (int i = 0; i < 4; i++) pend += lane_q[i].size();
      if (pend == 0 && exp_q.size() <= 1) drained = 1;
    end
    checkOutput("drain_done", {31'd0, drained}, 32'd1);
    idleCycles(4, 1'b1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
